scm_1rw_burst_port: RTL

- Initiator-side port controller that owns the single address/write port of a 1RW latch-based standard cell memory (SCM).
- Memory read data is combinational from the address; a write becomes readable only one cycle after it is issued.
- Block merges two traffic sources onto that port:
  - a single-word write interface, which is always accepted and has priority;
  - a burst-read engine that takes (start address, length) requests and streams words out over a valid/ready interface with backpressure.
- Sits between cluster-side logic and the SCM macro.

---
 rtl/scm_1rw_burst_port.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/scm_1rw_burst_port.sv
// rtl/scm_1rw_burst_port.sv - single-port SCM controller merging word writes with a burst-read stream
//
// Owns the only address/write port of a 1RW latch-based SCM. Writes are always
// accepted and take the port. Burst reads fill a 2-entry output FIFO. The FIFO head
// drives the rd_* stream.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   req_valid_i/req_ready_o          burst request handshake
//   req_addr_i, req_len_i            burst start address, length minus one
//   abort_i                          cancel the current burst and flush buffered words
//   wr_valid_i, wr_addr_i, wr_data_i single-word write, always accepted
//   mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i         SCM port; read data is combinational from address
//   rd_valid_o/rd_ready_i,
//   rd_data_o, rd_last_o             output word stream
//   busy_o                           burst in progress (READ or DRAIN)
//   stall_cnt_o                      READ cycles without an issued read; present only
//                                    when SCM_1RW_BURST_PERF_EN is defined
module scm_1rw_burst_port #(
  parameter int WORD_WIDTH = 25,
  parameter int ROW_CNT    = 64,
  localparam int ADDR_WIDTH = $clog2(ROW_CNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [ADDR_WIDTH-1:0] req_len_i,
  input  logic                  abort_i,
  input  logic                  wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  output logic                  rd_last_o,
`ifdef SCM_1RW_BURST_PERF_EN
  output logic [31:0]           stall_cnt_o,
`endif
  output logic                  busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    haz_valid_q, haz_valid_d;
  logic [ADDR_WIDTH-1:0]   haz_addr_q, haz_addr_d;
  logic [1:0]              fifo_cnt_q, fifo_cnt_d;
  logic [WORD_WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
  logic                    last0_q, last0_d, last1_q, last1_d;

  logic       pop;
  logic       fifo_full;
  logic       hazard;
  logic       issue;
  logic       req_hs;
  logic [1:0] fifo_cnt_after_pop;

  assign pop       = (fifo_cnt_q != 2'd0) && rd_ready_i;
  // A full FIFO can still take a word when its head leaves in the same cycle.
  assign fifo_full = (fifo_cnt_q == 2'd2) && !pop;
  // The SCM only shows a write one cycle later, so reading that address now would
  // return stale data.
  assign hazard    = haz_valid_q && (haz_addr_q == addr_q);
  assign issue     = (state_q == S_READ) && !wr_valid_i && !fifo_full && !hazard && !abort_i;
  assign req_hs    = (state_q == S_IDLE) && req_valid_i;
  assign fifo_cnt_after_pop = fifo_cnt_q - {1'b0, pop};

  assign mem_we_o    = wr_valid_i;
  assign mem_addr_o  = wr_valid_i ? wr_addr_i : addr_q;
  assign mem_wdata_o = wr_data_i;

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign rd_valid_o  = (fifo_cnt_q != 2'd0);
  assign rd_data_o   = data0_q;
  assign rd_last_o   = last0_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    haz_valid_d = wr_valid_i;
    haz_addr_d  = wr_addr_i;
    data0_d     = data0_q;
    data1_d     = data1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    fifo_cnt_d  = fifo_cnt_after_pop + {1'b0, issue};

    if (pop) begin
      data0_d = data1_q;
      last0_d = last1_q;
    end
    if (issue) begin
      // The new word lands behind whatever is left after this cycle's pop.
      if (fifo_cnt_after_pop == 2'd0) begin
        data0_d = mem_rdata_i;
        last0_d = (cnt_q == '0);
      end else begin
        data1_d = mem_rdata_i;
        last1_d = (cnt_q == '0);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          cnt_d   = req_len_i;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - ADDR_WIDTH'(1);
          if (cnt_q == '0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_i || (fifo_cnt_q == 2'd0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) fifo_cnt_d = 2'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      haz_valid_q <= 1'b0;
      haz_addr_q  <= '0;
      fifo_cnt_q  <= 2'd0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      haz_valid_q <= haz_valid_d;
      haz_addr_q  <= haz_addr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
    end
  end

`ifdef SCM_1RW_BURST_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_hs) begin
      stall_cnt_d = 32'd0;
    end else if ((state_q == S_READ) && !issue && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  logic unused_req_hs;
  assign unused_req_hs = req_hs;
`endif

endmodule
